// File: rtl/freq_pkg.sv
// Shared encodings and default ratios for the CPU clock divider
// and the clock-health meter that watches it.
package freq_pkg;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_MEAS = 1'b1
    } state_e;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_EXP_PERIOD = 4;
    localparam int DEF_TOL        = 0;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_TIMEOUT    = 1024;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus a history flop for rising-edge detection
// of an asynchronous level sampled in the clk domain.
module sync_edge
    import freq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign lvl_o  = s2_q;
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a divided clock in clk cycles,
// flags lock against the expected ratio and a missing-edge timeout.
module freq_meter
    import freq_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout_err
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_V    = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TOL_V    = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [MW-1:0]    LOCK_V   = MW'(LOCK_CNT);

    logic lvl, rise;

    sync_edge u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (clk_in),
        .lvl_o  (lvl),
        .rise_o (rise)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [MW-1:0]    match_q, match_d;
    logic             meas_q, meas_d;
    logic             locked_q, locked_d;
    logic             tmo_q, tmo_d;

    logic [CNT_W-1:0] period_new, diff;
    logic [CNT_W-1:0] cnt_inc, hcnt_inc;
    logic             match;

    assign period_new = cnt_q + ONE;
    // Unsigned max-min so an under-speed period never wraps into a match.
    assign diff = (period_new >= EXP_V) ? period_new - EXP_V
                                        : EXP_V - period_new;
    assign match = (diff <= TOL_V);

    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;
    assign hcnt_inc = (lvl && hcnt_q != CNT_MAX) ? hcnt_q + ONE
                                                 : hcnt_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        match_d  = match_q;
        meas_d   = 1'b0;
        locked_d = locked_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_WAIT: begin
                if (rise) begin
                    state_d = S_MEAS;
                    cnt_d   = '0;
                    hcnt_d  = ONE;
                    tmo_d   = 1'b0;
                end
            end
            S_MEAS: begin
                if (rise) begin
                    period_d = period_new;
                    high_d   = hcnt_q;
                    meas_d   = 1'b1;
                    cnt_d    = '0;
                    hcnt_d   = ONE;
                    if (!match) begin
                        match_d = '0;
                    end else if (match_q != LOCK_V) begin
                        match_d = match_q + MW'(1);
                    end
                    locked_d = (match_d == LOCK_V);
                end else if (cnt_q == TMO_LAST) begin
                    state_d  = S_WAIT;
                    tmo_d    = 1'b1;
                    locked_d = 1'b0;
                    match_d  = '0;
                end else begin
                    cnt_d  = cnt_inc;
                    hcnt_d = hcnt_inc;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_WAIT;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            match_q  <= '0;
            meas_q   <= 1'b0;
            locked_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            match_q  <= match_d;
            meas_q   <= meas_d;
            locked_q <= locked_d;
            tmo_q    <= tmo_d;
        end
    end

    assign period      = period_q;
    assign high_time   = high_q;
    assign meas_valid  = meas_q;
    assign locked      = locked_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench: instance a runs the default 4-cycle ratio,
// instance b an 8-cycle, 25% duty clock with an 8-cycle timeout.
module tb_freq_meter;

    typedef struct {
        logic [15:0] per;
        logic [15:0] hi;
        logic        lk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n_a, rst_n_b;
    logic        clk_in_a, clk_in_b;
    logic [15:0] period_a, high_a, period_b, high_b;
    logic        mv_a, lk_a, tmo_a, mv_b, lk_b, tmo_b;

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    freq_meter #(
        .CNT_W(16), .EXP_PERIOD(4), .TOL(0),
        .LOCK_CNT(4), .TIMEOUT(1024)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n_a),
        .clk_in      (clk_in_a),
        .period      (period_a),
        .high_time   (high_a),
        .meas_valid  (mv_a),
        .locked      (lk_a),
        .timeout_err (tmo_a)
    );

    freq_meter #(
        .CNT_W(16), .EXP_PERIOD(8), .TOL(0),
        .LOCK_CNT(4), .TIMEOUT(8)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n_b),
        .clk_in      (clk_in_b),
        .period      (period_b),
        .high_time   (high_b),
        .meas_valid  (mv_b),
        .locked      (lk_b),
        .timeout_err (tmo_b)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic mon(input string name, input logic [15:0] per,
                       input logic [15:0] hi, input logic lk,
                       inout exp_t q[$]);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: got per=%0d hi=%0d lk=%0d",
                     name, per, hi, lk);
        end else begin
            e = q.pop_front();
            if (per !== e.per || hi !== e.hi || lk !== e.lk) begin
                errors++;
                $display("FAIL %s_meas: got per=%0d hi=%0d lk=%0d want per=%0d hi=%0d lk=%0d",
                         name, per, hi, lk, e.per, e.hi, e.lk);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mv_a) mon("a", period_a, high_a, lk_a, qa);
        if (mv_b) mon("b", period_b, high_b, lk_b, qb);
    end

    // One clk_in period starting at the current negedge; the rising
    // edge it issues completes the measurement of the previous period.
    task automatic pulse(input bit b, input int per, input int hi,
                         input bit ev, input int ep, input int eh,
                         input bit el);
        exp_t e;
        if (ev) begin
            e.per = 16'(ep);
            e.hi  = 16'(eh);
            e.lk  = el;
            if (b) qb.push_back(e);
            else   qa.push_back(e);
        end
        if (b) clk_in_b = 1'b1;
        else   clk_in_a = 1'b1;
        repeat (hi) @(negedge clk);
        if (b) clk_in_b = 1'b0;
        else   clk_in_a = 1'b0;
        repeat (per - hi) @(negedge clk);
    endtask

    initial begin
        rst_n_a  = 1'b0;
        rst_n_b  = 1'b0;
        clk_in_a = 1'b0;
        clk_in_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", 32'(period_a), 0);
        chk("rst_high", 32'(high_a), 0);
        chk("rst_mv", 32'(mv_a), 0);
        chk("rst_locked", 32'(lk_a), 0);
        chk("rst_tmo", 32'(tmo_a), 0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        pulse(0, 4, 2, 0, 0, 0, 0);
        pulse(0, 4, 2, 1, 4, 2, 0);
        pulse(0, 4, 2, 1, 4, 2, 0);
        pulse(0, 4, 2, 1, 4, 2, 0);
        pulse(0, 4, 2, 1, 4, 2, 1);
        pulse(0, 6, 2, 1, 4, 2, 1);
        pulse(0, 4, 2, 1, 6, 2, 0);
        pulse(0, 4, 2, 1, 4, 2, 0);
        pulse(0, 4, 2, 1, 4, 2, 0);
        pulse(0, 4, 2, 1, 4, 2, 0);
        pulse(0, 4, 2, 1, 4, 2, 1);

        repeat (1022) @(negedge clk);
        chk("pre_tmo", 32'(tmo_a), 0);
        chk("pre_tmo_locked", 32'(lk_a), 1);
        @(negedge clk);
        chk("tmo_set", 32'(tmo_a), 1);
        chk("tmo_unlock", 32'(lk_a), 0);

        pulse(0, 4, 2, 0, 0, 0, 0);
        chk("tmo_clear", 32'(tmo_a), 0);
        pulse(0, 4, 2, 1, 4, 2, 0);
        pulse(0, 4, 2, 1, 4, 2, 0);
        pulse(0, 4, 2, 1, 4, 2, 0);
        pulse(0, 4, 2, 1, 4, 2, 1);

        clk_in_a = 1'b1;
        @(negedge clk);
        chk("pre_rst_locked", 32'(lk_a), 1);
        #2 rst_n_a = 1'b0;
        #1;
        chk("arst_period", 32'(period_a), 0);
        chk("arst_high", 32'(high_a), 0);
        chk("arst_mv", 32'(mv_a), 0);
        chk("arst_locked", 32'(lk_a), 0);
        chk("arst_tmo", 32'(tmo_a), 0);
        @(negedge clk);
        clk_in_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_a = 1'b1;
        pulse(0, 4, 2, 0, 0, 0, 0);
        pulse(0, 4, 2, 1, 4, 2, 0);

        pulse(1, 8, 2, 0, 0, 0, 0);
        pulse(1, 8, 2, 1, 8, 2, 0);
        pulse(1, 8, 2, 1, 8, 2, 0);
        pulse(1, 8, 2, 1, 8, 2, 0);
        pulse(1, 8, 2, 1, 8, 2, 1);
        pulse(1, 8, 2, 1, 8, 2, 1);
        chk("b_no_tmo", 32'(tmo_b), 0);
        repeat (2) @(negedge clk);
        chk("b_pre_tmo", 32'(tmo_b), 0);
        @(negedge clk);
        chk("b_tmo", 32'(tmo_b), 1);

        repeat (4) @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 0);
        chk("b_queue_drained", 32'(qb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
